// File: rtl/iter_div_ctrl.sv
// Iterative divider controller for the EX stage.
// Handles DIV/DIVU/REM/REMU and their W forms, one restoring step per clock.
// The divide-by-zero and signed-overflow cases resolve in a single cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for en; operands latched on the start cycle
// CALC   | one restoring-division step per cycle, counter runs down
// DONE   | result held on out with out_valid until out_ready or abort
module iter_div_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic        div_word,
  input  logic        en,
  input  logic [1:0]  op,
  output logic [63:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [6:0]  r_cnt;
  logic [63:0] r_dvs;
  logic [63:0] r_quo;
  logic [63:0] r_rem;
  logic [63:0] r_result;
  logic        r_word;
  logic        r_sel_rem;
  logic        r_neg_q;
  logic        r_neg_r;

  // Operand decode on the start cycle (op[0]=0 means signed, op[1]=1 means remainder)
  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_a_sext;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_a_mag;
  logic [63:0] w_b_mag;
  logic        w_b_zero;
  logic        w_ovf;
  logic        w_special;
  logic [63:0] w_spec_quo;
  logic [63:0] w_spec_rem;
  logic [63:0] w_spec_res;
  logic [63:0] w_quo_init;
  logic [6:0]  w_n;

  assign w_signed = ~op[0];
  assign w_a_sext = div_word ? {{32{in1[31]}}, in1[31:0]} : in1;
  assign w_a_ext  = div_word ? (w_signed ? {{32{in1[31]}}, in1[31:0]} : {32'd0, in1[31:0]}) : in1;
  assign w_b_ext  = div_word ? (w_signed ? {{32{in2[31]}}, in2[31:0]} : {32'd0, in2[31:0]}) : in2;
  assign w_a_neg  = w_signed & w_a_ext[63];
  assign w_b_neg  = w_signed & w_b_ext[63];
  // Negating the most-negative value wraps to itself, which is the right unsigned magnitude
  assign w_a_mag  = w_a_neg ? (-w_a_ext) : w_a_ext;
  assign w_b_mag  = w_b_neg ? (-w_b_ext) : w_b_ext;
  assign w_b_zero = (w_b_ext == 64'd0);
  assign w_ovf    = w_signed & (w_b_ext == {64{1'b1}}) &
                    (w_a_ext == (div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  assign w_special  = w_b_zero | w_ovf;
  // Overflow quotient equals the (sign-extended) dividend; zero divisor gives all ones
  assign w_spec_quo = w_b_zero ? {64{1'b1}} : w_a_ext;
  assign w_spec_rem = w_b_zero ? w_a_sext : 64'd0;
  assign w_spec_res = op[1] ? w_spec_rem : w_spec_quo;
  // W forms park the 32-bit dividend in the upper half so the step logic is shared
  assign w_quo_init = div_word ? {w_a_mag[31:0], 32'd0} : w_a_mag;
  assign w_n        = div_word ? 7'd32 : 7'd64;

  // One restoring-division step
  logic [64:0] w_shift;
  logic [64:0] w_sub;
  logic        w_ge;
  logic [63:0] w_rem_nxt;
  logic [63:0] w_quo_nxt;

  assign w_shift   = {r_rem, r_quo[63]};
  assign w_sub     = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_sub[64];
  assign w_rem_nxt = w_ge ? w_sub[63:0] : w_shift[63:0];
  assign w_quo_nxt = {r_quo[62:0], w_ge};

  // Sign fix and W-form sign extension applied to the final step's result
  logic [63:0] w_q_raw;
  logic [63:0] w_q_fix;
  logic [63:0] w_r_fix;
  logic [63:0] w_res_sel;
  logic [63:0] w_res_fin;

  assign w_q_raw   = r_word ? {32'd0, w_quo_nxt[31:0]} : w_quo_nxt;
  assign w_q_fix   = r_neg_q ? (-w_q_raw) : w_q_raw;
  assign w_r_fix   = r_neg_r ? (-w_rem_nxt) : w_rem_nxt;
  assign w_res_sel = r_sel_rem ? w_r_fix : w_q_fix;
  assign w_res_fin = r_word ? {{32{w_res_sel[31]}}, w_res_sel[31:0]} : w_res_sel;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; dropping en in CALC or DONE aborts back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (!en)                w_state_nxt = S_IDLE;
        else if (r_cnt == 7'd1) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!en || out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out       = r_result;
    if (r_state == S_DONE) out_valid = 1'b1;
    if (r_state != S_IDLE) busy      = 1'b1;
  end

  // Datapath: operand latch, iteration, counter and result register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= 7'd0;
      r_dvs     <= 64'd0;
      r_quo     <= 64'd0;
      r_rem     <= 64'd0;
      r_result  <= 64'd0;
      r_word    <= 1'b0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_word    <= div_word;
            r_sel_rem <= op[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_dvs     <= w_b_mag;
            r_quo     <= w_quo_init;
            r_rem     <= 64'd0;
            if (w_special) begin
              r_result <= w_spec_res;
              r_cnt    <= 7'd0;
            end else begin
              r_cnt    <= w_n;
            end
          end
        end
        S_CALC: begin
          if (en) begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - 7'd1;
            if (r_cnt == 7'd1) r_result <= w_res_fin;
          end else begin
            r_cnt <= 7'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_ctrl.sv
// Scoreboard bench for iter_div_ctrl: stimulus pushes expected result and
// arrival cycle, a negedge monitor pops and compares when out_valid rises.
module tb_iter_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] in1;
  logic [63:0] in2;
  logic        div_word;
  logic        en;
  logic [1:0]  op;
  logic [63:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  iter_div_ctrl dut (
    .clock(clock), .reset(reset), .in1(in1), .in2(in2), .div_word(div_word),
    .en(en), .op(op), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] val;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] held = 64'd0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  // Monitor: compare on out_valid rising, check hold stability while it stays high
  always @(negedge clock) begin
    exp_t e;
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid got out=%h at cyc=%0d, want no result", out, cyc);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (out !== e.val) begin
          failures++;
          $display("FAIL %s_value got=%h want=%h", e.nm, out, e.val);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL %s_latency got cyc=%0d want cyc=%0d", e.nm, cyc, e.cyc);
        end
      end
    end else if (out_valid && prev_valid) begin
      checks++;
      if (out !== held) begin
        failures++;
        $display("FAIL hold_stable got=%h want=%h", out, held);
      end
    end
    prev_valid = out_valid;
    held       = out;
  end

  // Issue one op at the current negedge, scramble inputs after the start
  // cycle, wait for the result and release it; ends with state IDLE.
  task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] expv, input int lat,
                        input string nm, input int hold);
    exp_t e;
    int   n;
    in1 = a; in2 = b; op = o; div_word = w; en = 1'b1;
    out_ready = (hold == 0);
    e.val = expv; e.cyc = cyc + lat; e.nm = nm;
    exp_q.push_back(e);
    @(negedge clock);
    in1 = ~a; in2 = 64'd0; op = ~o;
    n = 0;
    while (!out_valid && n < 150) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL %s_timeout got no out_valid within 150 cycles, want result", nm);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      en = 1'b0;
      @(negedge clock);
      return;
    end
    if (hold != 0) begin
      repeat (3) @(negedge clock);
      out_ready = 1'b1;
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release got busy=%b valid=%b want 0/0", nm, busy, out_valid);
    end
    en = 1'b0;
  endtask

  initial begin
    int s;
    int saw;
    reset = 1'b1; en = 1'b0; out_ready = 1'b0; in1 = 64'd0; in2 = 64'd0;
    op = 2'b00; div_word = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out !== 64'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b valid=%b out=%h want 0/0/0", busy, out_valid, out);
    end
    reset = 1'b0;
    @(negedge clock);

    run_op(DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, "div_neg", 0);
    run_op(REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem_neg", 0);
    @(negedge clock);
    run_op(REMU, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd16, 64'h9, 33, "remuw", 0);
    run_op(DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd16, 64'h0000_0000_0FFF_FFFF, 33, "divuw", 0);
    run_op(DIVU, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_zero", 0);
    run_op(REMU, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 1, "remu_zero", 0);
    run_op(DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf", 0);
    run_op(REM,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1, "remw_ovf", 0);
    run_op(DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, "div_ovf", 0);
    run_op(REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_ovf", 0);
    run_op(DIV,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw_neg", 0);
    run_op(REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw_neg", 0);
    run_op(DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, "divuw_sext", 0);
    run_op(DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_negdvs", 0);
    run_op(REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, "rem_negdvs", 0);
    run_op(REM,  1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, "remw_zero", 0);
    run_op(DIVU, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divuw_zero", 0);
    run_op(DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65, "divu_hold", 1);

    // Reset in CALC cycle 10 with en and out_ready still high
    @(negedge clock);
    in1 = 64'd1000; in2 = 64'd9; op = DIVU; div_word = 1'b0; en = 1'b1; out_ready = 1'b1;
    s = cyc;
    while (cyc < s + 10) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL calc_busy got busy=%b want 1", busy);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out !== 64'd0) begin
      failures++;
      $display("FAIL mid_reset got busy=%b valid=%b out=%h want 0/0/0", busy, out_valid, out);
    end
    reset = 1'b0; en = 1'b0;
    @(negedge clock);
    run_op(DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, "divu_after_reset", 0);

    // Abort by dropping en mid-CALC: no result may appear
    @(negedge clock);
    in1 = 64'd500; in2 = 64'd5; op = DIV; div_word = 1'b0; en = 1'b1; out_ready = 1'b1;
    repeat (5) @(negedge clock);
    en = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b want 0", busy);
    end
    saw = 0;
    repeat (70) begin
      @(negedge clock);
      if (out_valid) saw = 1;
    end
    checks++;
    if (saw != 0) begin
      failures++;
      $display("FAIL abort_no_valid got out_valid seen, want never");
    end
    run_op(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_after_abort", 0);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expect got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish by time limit, want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
